// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard, a post-reset zeroing sweep and registered reads.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module regfile_sb #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            ready,
   input  logic            we,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] data2,
   input  logic            busy_set,
   input  logic [AW-1:0]   busy_rd,
   output logic            busy1,
   output logic            busy2
);

   typedef enum logic {ST_SWEEP, ST_RUN} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_sweep_cnt;
   logic [AW-1:0]     w_sweep_cnt_nxt;
   logic [XLEN-1:0]   r_regs [NREGS];
   logic [NREGS-1:0]  r_busy;
   logic [NREGS-1:0]  w_busy_nxt;
   logic [XLEN-1:0]   r_data1;
   logic [XLEN-1:0]   r_data2;
   logic              r_busy1;
   logic              r_busy2;
   logic              w_run;
   logic              w_wr_en;
   logic [XLEN-1:0]   w_rd1;
   logic [XLEN-1:0]   w_rd2;

   // ready is the decoded FSM state, so it doubles as the state observation point
   assign w_run   = (r_state == ST_RUN);
   assign ready   = w_run;
   assign w_wr_en = w_run & we & (rd != '0);

   assign data1 = r_data1;
   assign data2 = r_data2;
   assign busy1 = r_busy1;
   assign busy2 = r_busy2;

   always_comb begin
      w_state_nxt     = r_state;
      w_sweep_cnt_nxt = r_sweep_cnt;
      case (r_state)
         ST_SWEEP: begin
            w_sweep_cnt_nxt = r_sweep_cnt + AW'(1);
            if (r_sweep_cnt == LAST_IDX) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_SWEEP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SWEEP;
         r_sweep_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_cnt <= w_sweep_cnt_nxt;
      end
   end

   // Array has no reset; gating on rst_n drops any write while reset is held
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!w_run) begin
            r_regs[r_sweep_cnt] <= '0;
         end else if (w_wr_en) begin
            r_regs[rd] <= wd;
         end
      end
   end

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_run) begin
         if (w_wr_en) begin
            w_busy_nxt[rd] = 1'b0;
         end
         // set is applied after clear so it wins on a same-index collision
         if (busy_set && (busy_rd != '0)) begin
            w_busy_nxt[busy_rd] = 1'b1;
         end
      end
   end

   always_comb begin
      w_rd1 = (rs1 == '0) ? '0 : r_regs[rs1];
      w_rd2 = (rs2 == '0) ? '0 : r_regs[rs2];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (rs1 == rd)) begin
         w_rd1 = wd;
      end
      if (w_wr_en && (rs2 == rd)) begin
         w_rd2 = wd;
      end
`else
      w_rd1 = w_rd1;
      w_rd2 = w_rd2;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
         r_busy1 <= 1'b0;
         r_busy2 <= 1'b0;
      end else if (!w_run) begin
         r_data1 <= '0;
         r_data2 <= '0;
         r_busy1 <= 1'b0;
         r_busy2 <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_data1 <= w_rd1;
         r_data2 <= w_rd2;
         r_busy1 <= w_busy_nxt[rs1];
         r_busy2 <= w_busy_nxt[rs2];
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep timing, writes/reads, index-0 rules, bypass behaviour,
// scoreboard set/clear priority and mid-sweep reset.
module tb_regfile_sb;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   logic            clk;
   logic            rst_n;
   logic            ready;
   logic            we;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] wd;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic            busy_set;
   logic [AW-1:0]   busy_rd;
   logic            busy1;
   logic            busy2;

   int n_checks;
   int n_errors;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .we       (we),
      .rd       (rd),
      .wd       (wd),
      .rs1      (rs1),
      .rs2      (rs2),
      .data1    (data1),
      .data2    (data2),
      .busy_set (busy_set),
      .busy_rd  (busy_rd),
      .busy1    (busy1),
      .busy2    (busy2)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we       = 1'b0;
      rd       = '0;
      wd       = '0;
      busy_set = 1'b0;
      busy_rd  = '0;
   endtask

   task automatic write_reg(input logic [AW-1:0] idx, input logic [XLEN-1:0] val);
      we = 1'b1;
      rd = idx;
      wd = val;
      tick();
      we = 1'b0;
   endtask

   // counts edges after release until ready; expired budget reported as 999
   task automatic wait_ready(output int edges);
      edges = 999;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ready === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   int edges;
   logic [XLEN-1:0] prior7;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      rs1      = '0;
      rs2      = '0;
      idle_inputs();

      #22;
      check("rst_ready", {63'd0, ready}, 64'd0);
      check("rst_data1", data1, 64'd0);
      check("rst_busy1", {63'd0, busy1}, 64'd0);

      // release with we/busy_set active: both must be ignored during the sweep
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      we       = 1'b1;
      rd       = 5'd4;
      wd       = 64'h55;
      busy_set = 1'b1;
      busy_rd  = 5'd4;
      rs1      = 5'd4;
      rs2      = 5'd4;
      tick();
      tick();
      check("sweep_data1_held", data1, 64'd0);
      check("sweep_busy1_held", {63'd0, busy1}, 64'd0);
      edges = 2;
      for (int i = 3; i <= 40; i++) begin
         tick();
         if (ready === 1'b1) begin
            edges = i;
            break;
         end
         if (i == 40) edges = 999;
      end
      idle_inputs();
      check("sweep_edges", 64'(edges), 64'd32);

      // every index reads zero, no busy flags pending
      for (int i = 0; i < NREGS; i++) begin
         rs1 = AW'(i);
         rs2 = AW'(NREGS - 1 - i);
         tick();
         check("clear_data1", data1, 64'd0);
         check("clear_data2", data2, 64'd0);
         if (i == 4) check("sweep_busy_ignored", {63'd0, busy1}, 64'd0);
      end

      // basic write then read
      write_reg(5'd5, 64'hDEAD_BEEF_0123_4567);
      rs1 = 5'd5;
      tick();
      check("wr5_rd1", data1, 64'hDEAD_BEEF_0123_4567);

      // same index on both ports
      rs2 = 5'd5;
      tick();
      check("same_idx_d1", data1, 64'hDEAD_BEEF_0123_4567);
      check("same_idx_d2", data2, 64'hDEAD_BEEF_0123_4567);

      // two more patterns through both ports
      write_reg(5'd31, 64'hA5A5_0000_FFFF_1234);
      write_reg(5'd1, 64'h0000_0000_0000_0001);
      rs1 = 5'd31;
      rs2 = 5'd1;
      tick();
      check("wr31_rd1", data1, 64'hA5A5_0000_FFFF_1234);
      check("wr1_rd2", data2, 64'h1);

      // index 0: writes ignored, busy never set
      we       = 1'b1;
      rd       = '0;
      wd       = '1;
      busy_set = 1'b1;
      busy_rd  = '0;
      rs2      = '0;
      tick();
      idle_inputs();
      tick();
      check("r0_data2", data2, 64'd0);
      check("r0_busy2", {63'd0, busy2}, 64'd0);

      // same-cycle write/read of index 7
      prior7 = 64'h1234;
      write_reg(5'd7, prior7);
      we  = 1'b1;
      rd  = 5'd7;
      wd  = 64'd9;
      rs1 = 5'd7;
      tick();
      we = 1'b0;
`ifdef REGFILE_BYPASS_EN
      check("bypass_same_cycle", data1, 64'd9);
`else
      check("nobypass_same_cycle", data1, prior7);
`endif
      tick();
      check("r7_next_cycle", data1, 64'd9);

      // scoreboard set, then clear by write, then set wins over write
      busy_set = 1'b1;
      busy_rd  = 5'd3;
      rs1      = 5'd3;
      tick();
      check("busy3_set", {63'd0, busy1}, 64'd1);
      busy_set = 1'b0;
      we       = 1'b1;
      rd       = 5'd3;
      wd       = 64'h33;
      tick();
      check("busy3_clear", {63'd0, busy1}, 64'd0);
      busy_set = 1'b1;
      busy_rd  = 5'd3;
      tick();
      idle_inputs();
      check("busy3_set_wins", {63'd0, busy1}, 64'd1);
      tick();
      check("busy3_held", {63'd0, busy1}, 64'd1);

      // busy on port 2, other port unaffected
      busy_set = 1'b1;
      busy_rd  = 5'd9;
      rs2      = 5'd9;
      rs1      = 5'd5;
      tick();
      idle_inputs();
      check("busy9_port2", {63'd0, busy2}, 64'd1);
      check("busy5_port1", {63'd0, busy1}, 64'd0);

      // reset mid-run, release, then reset again at sweep_cnt=10
      rs1 = 5'd3;
      rst_n = 1'b0;
      #2;
      check("rerst_ready", {63'd0, ready}, 64'd0);
      check("rerst_busy1", {63'd0, busy1}, 64'd0);
      check("rerst_busy2", {63'd0, busy2}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      #2;
      check("midsweep_ready", {63'd0, ready}, 64'd0);
      check("midsweep_data1", data1, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ready(edges);
      check("midsweep_edges", 64'(edges), 64'd32);
      rs1 = 5'd3;
      rs2 = 5'd5;
      tick();
      check("post_rst_busy3", {63'd0, busy1}, 64'd0);
      check("post_rst_r5", data2, 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
